// File: rtl/mod_table_writer_pkg.sv
// Shared definitions for the modulo lookup table writer and its reader.
// FSM state encoding, default table dimensions and the address-width helper.
package mod_table_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_WIDTH = 12;
  localparam int DEFAULT_N_WIDTH   = 6;

  // Table address is {n-2, k}, so its width is the sum of both field widths.
  function automatic int addr_width(input int n_width, input int num_width);
    return n_width + num_width;
  endfunction

endpackage

// File: rtl/mod_table_writer_counter.sv
// mod_counter: incremental remainder register for the table writer.
// Holds k mod n without a divider: cleared on load, stepped on advance,
// wrapping back to zero once it reaches limit-1.
module mod_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Remainder update: load wins over advance; wrap when value reaches limit-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= '0;
    end else if (advance) begin
      if (value == limit - ONE) begin
        value <= '0;
      end else begin
        value <= value + ONE;
      end
    end
  end

endmodule

// File: rtl/mod_table_writer.sv
// mod_table_writer: fills a modulo lookup table with k mod n for every
// modulus n = 2 .. 2^N_WIDTH-1 and index k = 0 .. 2^NUM_WIDTH-1, one entry
// per accepted write, address {n-2, k}.
// Optional feature macro: MOD_TABLE_CHECKSUM_EN adds a 16-bit running sum of
// all transferred data words on port checksum.
module mod_table_writer
  import mod_table_writer_pkg::*;
#(
  parameter int NUM_WIDTH = DEFAULT_NUM_WIDTH,
  parameter int N_WIDTH   = DEFAULT_N_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       wr_en,
  output logic [addr_width(N_WIDTH, NUM_WIDTH)-1:0]  wr_addr,
  output logic [N_WIDTH-1:0]                         wr_data,
`ifdef MOD_TABLE_CHECKSUM_EN
  output logic [15:0]                                checksum,
`endif
  input  logic                                       wr_ready
);

  localparam logic [N_WIDTH-1:0]   N_FIRST = N_WIDTH'(2);
  localparam logic [N_WIDTH-1:0]   N_LAST  = '1;
  localparam logic [NUM_WIDTH-1:0] K_LAST  = '1;

  state_t state, state_next;

  logic [N_WIDTH-1:0]   n;
  logic [NUM_WIDTH-1:0] k;
  logic [N_WIDTH-1:0]   r;
  logic [N_WIDTH-1:0]   n_offset;

  logic start_go;
  logic xfer;
  logic k_wrap;
  logic last_entry;

  assign start_go   = (state == IDLE) && start;
  assign xfer       = (state == FILL) && wr_ready;
  assign k_wrap     = (k == K_LAST);
  assign last_entry = k_wrap && (n == N_LAST);
  assign n_offset   = n - N_FIRST;

  // Outputs are forced to zero outside FILL so reset and idle look identical.
  assign wr_addr = (state == FILL) ? {n_offset, k} : '0;
  assign wr_data = (state == FILL) ? r : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (xfer && last_entry) state_next = FIN;
      end
      FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Modulus and index walk: k inner, n outer; both advance only on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= '0;
      k <= '0;
    end else if (start_go) begin
      n <= N_FIRST;
      k <= '0;
    end else if (xfer) begin
      if (k_wrap) begin
        k <= '0;
        n <= n + N_WIDTH'(1);
      end else begin
        k <= k + NUM_WIDTH'(1);
      end
    end
  end

  mod_counter #(
    .WIDTH (N_WIDTH)
  ) u_rem (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_go | (xfer & k_wrap)),
    .advance (xfer & ~k_wrap),
    .limit   (n),
    .value   (r)
  );

`ifdef MOD_TABLE_CHECKSUM_EN
  // Running sum of transferred data; restarts with each fill, holds after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_go) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + 16'(wr_data);
    end
  end
`endif

endmodule

// File: tb/tb_mod_table_writer.sv
// Testbench for mod_table_writer with NUM_WIDTH=3, N_WIDTH=3 (48 entries).
module tb_mod_table_writer;

  localparam int KW = 3;
  localparam int NW = 3;
  localparam int AW = KW + NW;
  localparam int TOTAL = ((1 << NW) - 2) * (1 << KW);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NW-1:0] wr_data;
  logic          wr_ready;
`ifdef MOD_TABLE_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  mod_table_writer #(
    .NUM_WIDTH (KW),
    .N_WIDTH   (NW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`ifdef MOD_TABLE_CHECKSUM_EN
    .checksum (checksum),
`endif
    .wr_ready (wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_count  = 0;
  int check_count = 0;

  int got_addr[$];
  int got_data[$];
  int done_count;
  int done_cyc;
  int last_cyc;
  int stall_bad;
  bit finished;
  bit aborted;

  typedef struct {
    int idx;
    int addr;
    int data;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input longint got, input longint exp);
    check_count++;
    if (got == exp) begin
      pass_count++;
      $display("check %-22s got %0d expected %0d ok", name, got, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: entry at address a belongs to n = a / 2^KW + 2, k = a mod 2^KW.
  function automatic int ref_data(input int a);
    int n;
    int k;
    n = a / (1 << KW) + 2;
    k = a % (1 << KW);
    return k % n;
  endfunction

  // Pulse start and observe one fill; optionally poke start mid-fill / in FIN,
  // or pull reset after abort_at completed writes.
  task automatic run_fill(input bit rand_ready, input bit poke_fill,
                          input bit poke_fin, input int abort_at);
    bit stall;
    logic [AW-1:0] held_a;
    logic [NW-1:0] held_d;
    got_addr.delete();
    got_data.delete();
    done_count = 0;
    done_cyc   = -1;
    last_cyc   = -1;
    stall_bad  = 0;
    finished   = 0;
    aborted    = 0;
    stall      = 0;
    held_a     = '0;
    held_d     = '0;
    @(negedge clk);
    start    = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_wr_en", wr_en, 1);
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;
      if (abort_at > 0 && got_addr.size() == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_addr_data", {wr_addr, wr_data}, 0);
        aborted  = 1;
        finished = 1;
      end else begin
        wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (poke_fill && got_addr.size() == 10) start = 1'b1;
        if (stall && (!wr_en || wr_addr !== held_a || wr_data !== held_d)) stall_bad++;
        stall = 0;
        if (wr_en) begin
          if (wr_ready) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
            last_cyc = cyc;
          end else begin
            stall  = 1;
            held_a = wr_addr;
            held_d = wr_data;
          end
        end
        if (done) begin
          done_count++;
          done_cyc = cyc;
          finished = 1;
          if (poke_fin) start = 1'b1;
        end
      end
    end
    check("fill_terminated", finished, 1);
  endtask

  // Post-fill checks against the reference table.
  task automatic check_fill(input string tag);
    int seen[TOTAL];
    int order_bad;
    int data_bad;
    int dup_bad;
    int quiet_bad;
    order_bad = 0;
    data_bad  = 0;
    dup_bad   = 0;
    quiet_bad = 0;
    foreach (seen[i]) seen[i] = 0;
    check({tag, "_write_count"}, got_addr.size(), TOTAL);
    for (int i = 0; i < got_addr.size(); i++) begin
      if (got_addr[i] != i) order_bad++;
      if (got_addr[i] < TOTAL) begin
        seen[got_addr[i]]++;
        if (got_data[i] != ref_data(got_addr[i])) data_bad++;
      end else begin
        data_bad++;
      end
    end
    foreach (seen[i]) if (seen[i] != 1) dup_bad++;
    check({tag, "_order_errs"}, order_bad, 0);
    check({tag, "_data_errs"}, data_bad, 0);
    check({tag, "_once_errs"}, dup_bad, 0);
    check({tag, "_stall_errs"}, stall_bad, 0);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_done_timing"}, done_cyc, last_cyc + 1);
`ifdef MOD_TABLE_CHECKSUM_EN
    begin
      int sum;
      sum = 0;
      for (int a = 0; a < TOTAL; a++) sum += ref_data(a);
      check({tag, "_checksum"}, checksum, sum % 65536);
    end
`endif
    // FIN lasts exactly one cycle, then the block sits idle (start in FIN ignored).
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_after_fin"}, {busy, done, wr_en}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || wr_en || done) quiet_bad++;
    end
    check({tag, "_stays_idle"}, quiet_bad, 0);
  endtask

  initial begin
    int bad;
    vecs[0] = '{idx: 0,  addr: 0,  data: 0};
    vecs[1] = '{idx: 9,  addr: 9,  data: 1};
    vecs[2] = '{idx: 15, addr: 15, data: 1};
    vecs[3] = '{idx: 20, addr: 20, data: 0};
    vecs[4] = '{idx: 30, addr: 30, data: 1};
    vecs[5] = '{idx: 43, addr: 43, data: 3};
    vecs[6] = '{idx: 47, addr: 47, data: 0};

    rst_n    = 1'b0;
    start    = 1'b0;
    wr_ready = 1'b1;
    #12;
    check("reset_outputs", {busy, done, wr_en, wr_addr, wr_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // wr_ready high while idle must not create writes.
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wr_en || busy) bad++;
    end
    check("idle_quiet", bad, 0);

    // Back-to-back fill with wr_ready tied high.
    run_fill(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].idx < got_addr.size()) begin
        check($sformatf("vec%0d_addr", vecs[i].idx), got_addr[vecs[i].idx], vecs[i].addr);
        check($sformatf("vec%0d_data", vecs[i].idx), got_data[vecs[i].idx], vecs[i].data);
      end else begin
        check($sformatf("vec%0d_present", vecs[i].idx), got_addr.size(), vecs[i].idx + 1);
      end
    end
    check("consecutive_writes", last_cyc, TOTAL - 1);
    check_fill("full");

    // Randomly stalling memory.
    run_fill(1, 0, 0, 0);
    check_fill("stall");

    // Reset after 20 writes, then restart from the beginning.
    run_fill(0, 0, 0, 20);
    check("abort_taken", aborted, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("abort_no_done", bad, 0);
    run_fill(0, 0, 0, 0);
    check("restart_first_addr", got_addr.size() > 0 ? got_addr[0] : -1, 0);
    check_fill("restart");

    // start during FILL and during FIN must be ignored.
    run_fill(1, 1, 1, 0);
    check_fill("poke");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
